// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its neighbours: imem, the
// opcode decoder, register-file comparisons and the downstream stall source.
interface fetch_unit_if #(
  parameter int PC_WIDTH = 12
);
  logic                stall;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_q;
  logic                is_j;
  logic                is_jal;
  logic                is_jr;
  logic                is_bne;
  logic                is_blt;
  logic                is_bex;
  logic                rd_ne_rs;
  logic                rd_lt_rs;
  logic                rstatus_nz;
  logic [31:0]         rd_value;
  logic [31:0]         ifid_instr;
  logic [PC_WIDTH-1:0] ifid_pc;
  logic                ifid_valid;
  logic [PC_WIDTH-1:0] link_pc;
  logic                redirect;

  modport master (
    input  stall, imem_q,
    input  is_j, is_jal, is_jr, is_bne, is_blt, is_bex,
    input  rd_ne_rs, rd_lt_rs, rstatus_nz, rd_value,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, link_pc, redirect
  );

  modport slave (
    output stall, imem_q,
    output is_j, is_jal, is_jr, is_bne, is_blt, is_bex,
    output rd_ne_rs, rd_lt_rs, rstatus_nz, rd_value,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, link_pc, redirect
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage: holds the PC, addresses imem and keeps
// the IF/ID register; control transfers resolve in ID with one bubble.
module fetch_unit #(
  parameter int PC_WIDTH = 12
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);

  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         ifid_instr;
  logic [PC_WIDTH-1:0] ifid_pc;
  logic                ifid_valid;

  logic                take;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] branch_target;
  logic [31:0]         imm_sext;
  logic                unused_bits;

  assign bus.imem_addr  = pc;
  assign bus.ifid_instr = ifid_instr;
  assign bus.ifid_pc    = ifid_pc;
  assign bus.ifid_valid = ifid_valid;
  assign bus.link_pc    = ifid_pc + PC_WIDTH'(1);
  assign bus.redirect   = take;

  // Only registered ID state and decoder flags feed take; imem_q never does.
  assign take = ifid_valid & ~bus.stall &
                (bus.is_j | bus.is_jal | bus.is_jr |
                 (bus.is_bne & bus.rd_ne_rs) |
                 (bus.is_blt & bus.rd_lt_rs) |
                 (bus.is_bex & bus.rstatus_nz));

  assign imm_sext      = {{15{ifid_instr[16]}}, ifid_instr[16:0]};
  assign branch_target = ifid_pc + PC_WIDTH'(1) + imm_sext[PC_WIDTH-1:0];

  always_comb begin
    target = ifid_instr[PC_WIDTH-1:0];
    if (bus.is_jr) begin
      target = bus.rd_value[PC_WIDTH-1:0];
    end else if (bus.is_bne || bus.is_blt) begin
      target = branch_target;
    end
  end

  // Addresses wrap modulo 2^PC_WIDTH, so the high operand bits are dropped.
  assign unused_bits = ^{imm_sext[31:PC_WIDTH], bus.rd_value[31:PC_WIDTH]};

  // A taken transfer squashes the wrong-path word fetched alongside it.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= '0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else if (!bus.stall) begin
      ifid_pc <= pc;
      if (take) begin
        pc         <= target;
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end else begin
        pc         <= pc + PC_WIDTH'(1);
        ifid_instr <= bus.imem_q;
        ifid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, jumps, branches, stall,
// PC wrap and reset priority, with a tiny imem and opcode decoder model.
module tb_fetch_unit;

  localparam int PC_WIDTH = 12;

  localparam logic [31:0] J100   = {5'b00001, 27'd100};
  localparam logic [31:0] J4094  = {5'b00001, 27'd4094};
  localparam logic [31:0] JAL40  = {5'b00011, 27'd40};
  localparam logic [31:0] JR0    = {5'b00100, 27'd0};
  localparam logic [31:0] BNE_M3 = {5'b00010, 10'd0, 17'h1FFFD};
  localparam logic [31:0] BLT_P5 = {5'b00110, 10'd0, 17'd5};
  localparam logic [31:0] BEX50  = {5'b10110, 27'd50};

  logic        clock;
  logic        reset;
  logic [31:0] mem [0:4095];
  logic [4:0]  opc;
  int          n_assert;
  int          n_fail;

  fetch_unit_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  fetch_unit #(.PC_WIDTH(PC_WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign bus.imem_q = mem[bus.imem_addr];

  // Stand-in for the downstream opcode decoder.
  always_comb begin
    opc        = bus.ifid_instr[31:27];
    bus.is_j   = (opc == 5'b00001);
    bus.is_jal = (opc == 5'b00011);
    bus.is_jr  = (opc == 5'b00100);
    bus.is_bne = (opc == 5'b00010);
    bus.is_blt = (opc == 5'b00110);
    bus.is_bex = (opc == 5'b10110);
  end

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    mem[5]         = J100;
    reset          = 1'b1;
    bus.stall      = 1'b0;
    bus.rd_ne_rs   = 1'b0;
    bus.rd_lt_rs   = 1'b0;
    bus.rstatus_nz = 1'b0;
    bus.rd_value   = '0;

    tick();
    tick();
    check_output("reset_addr",     32'(bus.imem_addr), 32'd0);
    check_output("reset_valid",    32'(bus.ifid_valid), 32'd0);
    check_output("reset_instr",    bus.ifid_instr, 32'd0);
    check_output("reset_pc",       32'(bus.ifid_pc), 32'd0);
    check_output("reset_redirect", 32'(bus.redirect), 32'd0);
    reset = 1'b0;

    for (int k = 1; k <= 5; k++) begin
      tick();
      check_output("seq_addr",  32'(bus.imem_addr), 32'(k));
      check_output("seq_ifpc",  32'(bus.ifid_pc), 32'(k - 1));
      check_output("seq_instr", bus.ifid_instr, 32'(k - 1));
      check_output("seq_valid", 32'(bus.ifid_valid), 32'd1);
    end
    tick();
    check_output("j_id_pc",    32'(bus.ifid_pc), 32'd5);
    check_output("j_redirect", 32'(bus.redirect), 32'd1);
    tick();
    check_output("j_addr",     32'(bus.imem_addr), 32'd100);
    check_output("j_bubble",   32'(bus.ifid_valid), 32'd0);
    check_output("j_bub_instr", bus.ifid_instr, 32'd0);
    check_output("j_bub_redir", 32'(bus.redirect), 32'd0);
    tick();
    check_output("j_tgt_ifpc",  32'(bus.ifid_pc), 32'd100);
    check_output("j_tgt_valid", 32'(bus.ifid_valid), 32'd1);
    check_output("j_tgt_addr",  32'(bus.imem_addr), 32'd101);

    mem[5]       = 32'd5;
    mem[10]      = BNE_M3;
    bus.rd_ne_rs = 1'b1;
    apply_reset();
    repeat (11) tick();
    check_output("bne_id_pc",    32'(bus.ifid_pc), 32'd10);
    check_output("bne_redirect", 32'(bus.redirect), 32'd1);
    tick();
    check_output("bne_addr",     32'(bus.imem_addr), 32'd8);
    check_output("bne_bubble",   32'(bus.ifid_valid), 32'd0);
    bus.rd_ne_rs = 1'b0;
    repeat (3) tick();
    check_output("bnt_id_pc",    32'(bus.ifid_pc), 32'd10);
    check_output("bnt_redirect", 32'(bus.redirect), 32'd0);
    tick();
    check_output("bnt_addr",     32'(bus.imem_addr), 32'd12);
    check_output("bnt_valid",    32'(bus.ifid_valid), 32'd1);
    check_output("bnt_ifpc",     32'(bus.ifid_pc), 32'd11);

    mem[10] = 32'd10;
    mem[20] = JAL40;
    apply_reset();
    repeat (21) tick();
    bus.stall = 1'b1;
    #1;
    check_output("jal_stall_redir", 32'(bus.redirect), 32'd0);
    check_output("jal_link",        32'(bus.link_pc), 32'd21);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("stall_addr",  32'(bus.imem_addr), 32'd21);
      check_output("stall_ifpc",  32'(bus.ifid_pc), 32'd20);
      check_output("stall_instr", bus.ifid_instr, JAL40);
      check_output("stall_redir", 32'(bus.redirect), 32'd0);
    end
    bus.stall = 1'b0;
    #1;
    check_output("jal_redirect", 32'(bus.redirect), 32'd1);
    tick();
    check_output("jal_addr",   32'(bus.imem_addr), 32'd40);
    check_output("jal_bubble", 32'(bus.ifid_valid), 32'd0);
    check_output("jal_bub_pc", 32'(bus.ifid_pc), 32'd21);

    mem[20]     = 32'd20;
    mem[3]      = JR0;
    mem[12'h346] = J4094;
    bus.rd_value = 32'h0001_2345;
    apply_reset();
    repeat (4) tick();
    check_output("jr_redirect", 32'(bus.redirect), 32'd1);
    tick();
    check_output("jr_addr",     32'(bus.imem_addr), 32'h345);
    repeat (2) tick();
    check_output("j2_id_pc",    32'(bus.ifid_pc), 32'h346);
    check_output("j2_redirect", 32'(bus.redirect), 32'd1);
    tick();
    check_output("j2_addr",     32'(bus.imem_addr), 32'd4094);
    tick();
    check_output("pre_wrap",    32'(bus.imem_addr), 32'd4095);
    tick();
    check_output("wrap_addr",   32'(bus.imem_addr), 32'd0);
    check_output("wrap_ifpc",   32'(bus.ifid_pc), 32'd4095);
    check_output("wrap_valid",  32'(bus.ifid_valid), 32'd1);

    mem[3]       = 32'd3;
    mem[7]       = BLT_P5;
    bus.rd_lt_rs = 1'b1;
    apply_reset();
    repeat (8) tick();
    check_output("blt_id_pc",    32'(bus.ifid_pc), 32'd7);
    check_output("blt_redirect", 32'(bus.redirect), 32'd1);
    reset = 1'b1;
    tick();
    check_output("rst_blt_addr",  32'(bus.imem_addr), 32'd0);
    check_output("rst_blt_valid", 32'(bus.ifid_valid), 32'd0);
    check_output("rst_blt_instr", bus.ifid_instr, 32'd0);
    check_output("rst_blt_ifpc",  32'(bus.ifid_pc), 32'd0);
    reset = 1'b0;

    mem[7]         = 32'd7;
    mem[2]         = BEX50;
    bus.rstatus_nz = 1'b1;
    repeat (3) tick();
    check_output("bex_id_pc",    32'(bus.ifid_pc), 32'd2);
    check_output("bex_redirect", 32'(bus.redirect), 32'd1);
    tick();
    check_output("bex_addr",     32'(bus.imem_addr), 32'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
